// File: rtl/cpu_index_tracker.sv
// Per-CPU queue index tracker. It adjusts the count from NCH inter-CPU message channels in a single cycle.
// Define CPU_IDX_SAT_EN to clamp the count to its range and report clamps on a sticky idx_err.

`ifndef CPU_MSG_SIZE0
`define CPU_MSG_SIZE0 1
`endif
`ifndef STATE_SIZE0
`define STATE_SIZE0 1
`endif
`ifndef CPU_R_START
`define CPU_R_START 1
`endif
`ifndef CPU_R_END
`define CPU_R_END 2
`endif
`ifndef START_BEGIN
`define START_BEGIN 1
`endif
`ifndef FINISH_END
`define FINISH_END 2
`endif
`ifndef CPU_ACTIVE
`define CPU_ACTIVE 32'h8000_0000
`endif
`ifndef CPU_NONACTIVE
`define CPU_NONACTIVE 32'h0000_0000
`endif

module cpu_index_tracker #(
    parameter int IDX_W = 31,
    parameter int NCH   = 2,
    parameter int MSG_W = `CPU_MSG_SIZE0 + 1,
    parameter int ST_W  = `STATE_SIZE0 + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clk_oe,
    input  logic                     cpu_index_set,
    input  logic [IDX_W:0]           cpu_index_in,
    input  logic [ST_W-1:0]          state,
    input  logic                     ext_next_cpu_q,
    input  logic [NCH-1:0]           ext_vld,
    input  logic [NCH*MSG_W-1:0]     ext_cpu_msg_in,
    input  logic [NCH*(IDX_W+1)-1:0] ext_cpu_index,
    output logic [IDX_W:0]           cpu_index_out,
    output logic                     idx_active,
    output logic [1:0]               trk_state,
    output logic                     idx_err
);

    localparam int IW = IDX_W + 1;
    localparam int CW = $clog2(NCH + 1);

    localparam logic [MSG_W-1:0] MSG_R_START    = MSG_W'(`CPU_R_START);
    localparam logic [MSG_W-1:0] MSG_R_END      = MSG_W'(`CPU_R_END);
    localparam logic [ST_W-1:0]  ST_START_BEGIN = ST_W'(`START_BEGIN);
    localparam logic [ST_W-1:0]  ST_FINISH_END  = ST_W'(`FINISH_END);
    localparam logic [IDX_W:0]   IDX_ACTIVE     = {1'b1, {IDX_W{1'b0}}};
    localparam logic [IDX_W:0]   IDX_NONACTIVE  = '0;

    typedef enum logic [1:0] {
        INACT  = 2'd0,
        ACT    = 2'd1,
        SETTLE = 2'd2
    } trk_state_t;

    logic [IDX_W:0]   cpu_index_reg, cpu_index_next;
    trk_state_t       trk_reg, trk_next;
    logic             err_reg, err_next;

    logic             self_act;
    logic [IDX_W-1:0] own_cnt;
    logic [NCH-1:0]   own, inc, dec;
    logic             own_any;
    logic [CW-1:0]    inc_cnt, dec_cnt;
    logic [IDX_W:0]   net;
    logic [IDX_W+1:0] sum_ext;
    logic [IDX_W-1:0] cnt_result;
    logic             clamp;

    assign self_act = cpu_index_reg[IDX_W];
    assign own_cnt  = cpu_index_reg[IDX_W-1:0];

    // Per-channel classification: own / foreign, and the increment/decrement votes.
    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
            logic [IDX_W:0]   snd_idx;
            logic [MSG_W-1:0] snd_msg;
            logic             foreign;
            logic             snd_act;

            assign snd_idx = ext_cpu_index[gi*IW +: IW];
            assign snd_msg = ext_cpu_msg_in[gi*MSG_W +: MSG_W];
            assign snd_act = snd_idx[IDX_W];
            assign own[gi] = ext_vld[gi] && (snd_idx == cpu_index_reg);
            assign foreign = ext_vld[gi] && (snd_idx != cpu_index_reg);
            assign inc[gi] = foreign && !snd_act && (snd_msg == MSG_R_START) && self_act;
            assign dec[gi] = foreign &&
                             ((snd_act && (snd_msg == MSG_R_END) && self_act &&
                               (snd_idx[IDX_W-1:0] < own_cnt)) ||
                              (!snd_act && (snd_msg == MSG_R_START) && !self_act));
        end
    endgenerate

    assign own_any = |own;

    always_comb begin
        inc_cnt = '0;
        dec_cnt = '0;
        for (int i = 0; i < NCH; i++) begin
            inc_cnt = inc_cnt + CW'(inc[i]);
            dec_cnt = dec_cnt + CW'(dec[i]);
        end
    end

    // Two's-complement net delta; sign-extended by one bit so out-of-range results are detectable.
    assign net     = IW'(inc_cnt) - IW'(dec_cnt);
    assign sum_ext = {2'b00, own_cnt} + {net[IDX_W], net};

`ifdef CPU_IDX_SAT_EN
    always_comb begin
        cnt_result = sum_ext[IDX_W-1:0];
        clamp      = 1'b0;
        if (sum_ext[IDX_W+1]) begin
            cnt_result = '0;
            clamp      = 1'b1;
        end else if (sum_ext[IDX_W]) begin
            cnt_result = '1;
            clamp      = 1'b1;
        end
    end
`else
    logic unused_sum_hi;
    assign unused_sum_hi = ^sum_ext[IDX_W+1:IDX_W];
    assign cnt_result    = sum_ext[IDX_W-1:0];
    assign clamp         = 1'b0;
`endif

    always_comb begin
        cpu_index_next = cpu_index_reg;
        trk_next       = trk_reg;
        err_next       = err_reg;
        if (!clk_oe) begin
            if (trk_reg == SETTLE) begin
                trk_next = self_act ? ACT : INACT;
            end else if (own_any && (cpu_index_reg == '0) && (state == ST_START_BEGIN)) begin
                cpu_index_next = IDX_ACTIVE;
                trk_next       = ACT;
            end else begin
                cpu_index_next = {self_act, cnt_result};
                trk_next       = self_act ? ACT : INACT;
                err_next       = err_reg | clamp;
            end
        end else begin
            if (cpu_index_set) begin
                cpu_index_next = cpu_index_in;
                trk_next       = SETTLE;
                err_next       = 1'b0;
            end else if (!ext_next_cpu_q || !own_any) begin
                if (state == ST_START_BEGIN) begin
                    cpu_index_next[IDX_W] = 1'b1;
                    trk_next              = ACT;
                end else if (state == ST_FINISH_END) begin
                    cpu_index_next = IDX_NONACTIVE;
                    trk_next       = INACT;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cpu_index_reg <= '0;
            trk_reg       <= INACT;
            err_reg       <= 1'b0;
        end else begin
            cpu_index_reg <= cpu_index_next;
            trk_reg       <= trk_next;
            err_reg       <= err_next;
        end
    end

    assign cpu_index_out = cpu_index_reg;
    assign idx_active    = cpu_index_reg[IDX_W];
    assign trk_state     = trk_reg;
    assign idx_err       = err_reg;

endmodule

// File: tb/tb_cpu_index_tracker.sv
// Randomised bench for cpu_index_tracker against a behavioural model of the index rules.
// Honours CPU_IDX_SAT_EN the same way as the design.

`ifndef CPU_R_START
`define CPU_R_START 1
`endif
`ifndef CPU_R_END
`define CPU_R_END 2
`endif
`ifndef START_BEGIN
`define START_BEGIN 1
`endif
`ifndef FINISH_END
`define FINISH_END 2
`endif

module tb_cpu_index_tracker;
    localparam int NCH = 3;
    localparam longint CMAX = 64'h7FFF_FFFF;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               clk_oe = 1'b0;
    logic               cpu_index_set = 1'b0;
    logic [31:0]        cpu_index_in = '0;
    logic [1:0]         state = '0;
    logic               ext_next_cpu_q = 1'b0;
    logic [NCH-1:0]     ext_vld = '0;
    logic [NCH*2-1:0]   ext_cpu_msg_in = '0;
    logic [NCH*32-1:0]  ext_cpu_index = '0;
    logic [31:0]        cpu_index_out;
    logic               idx_active;
    logic [1:0]         trk_state;
    logic               idx_err;

    cpu_index_tracker #(.IDX_W(31), .NCH(NCH), .MSG_W(2), .ST_W(2)) dut (
        .clk(clk), .rst(rst), .clk_oe(clk_oe), .cpu_index_set(cpu_index_set),
        .cpu_index_in(cpu_index_in), .state(state), .ext_next_cpu_q(ext_next_cpu_q),
        .ext_vld(ext_vld), .ext_cpu_msg_in(ext_cpu_msg_in), .ext_cpu_index(ext_cpu_index),
        .cpu_index_out(cpu_index_out), .idx_active(idx_active), .trk_state(trk_state),
        .idx_err(idx_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: index word, tracker state (0 inactive, 1 active, 2 settling), sticky error.
    logic [31:0] m_idx = '0;
    int          m_st  = 0;
    bit          m_err = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            check("index", cpu_index_out, m_idx);
            check("active", 32'(idx_active), 32'(m_idx[31]));
            check("trk_state", 32'(trk_state), 32'(m_st));
            check("idx_err", 32'(idx_err), 32'(m_err));
        end
    end

    task automatic model_step();
        bit     own_any = 1'b0;
        int     net = 0;
        bit     act = m_idx[31];
        longint cnt = longint'(m_idx[30:0]);
        longint nc;
        for (int k = 0; k < NCH; k++) begin
            logic [31:0] s_idx = ext_cpu_index[k*32 +: 32];
            logic [1:0]  s_msg = ext_cpu_msg_in[k*2 +: 2];
            if (ext_vld[k]) begin
                if (s_idx == m_idx) own_any = 1'b1;
                else if (s_idx[31]) begin
                    if (s_msg == 2'(`CPU_R_END) && act && longint'(s_idx[30:0]) < cnt) net--;
                end else if (s_msg == 2'(`CPU_R_START)) begin
                    net += act ? 1 : -1;
                end
            end
        end
        if (!clk_oe) begin
            if (m_st == 2) m_st = act ? 1 : 0;
            else if (own_any && m_idx == 0 && state == 2'(`START_BEGIN)) begin
                m_idx = 32'h8000_0000;
                m_st  = 1;
            end else begin
                nc = cnt + net;
`ifdef CPU_IDX_SAT_EN
                if (nc < 0) begin nc = 0; m_err = 1'b1; end
                else if (nc > CMAX) begin nc = CMAX; m_err = 1'b1; end
`else
                nc = nc & CMAX;
`endif
                m_idx = {act, nc[30:0]};
            end
        end else if (cpu_index_set) begin
            m_idx = cpu_index_in;
            m_st  = 2;
            m_err = 1'b0;
        end else if (!ext_next_cpu_q || !own_any) begin
            if (state == 2'(`START_BEGIN)) begin
                m_idx[31] = 1'b1;
                m_st      = 1;
            end else if (state == 2'(`FINISH_END)) begin
                m_idx = '0;
                m_st  = 0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst) model_step();
        #1;
    endtask

    task automatic set_ch(input int k, input bit v, input logic [1:0] msg, input logic [31:0] idx);
        ext_vld[k]               = v;
        ext_cpu_msg_in[k*2 +: 2] = msg;
        ext_cpu_index[k*32 +: 32] = idx;
    endtask

    task automatic idle_inputs();
        clk_oe = 1'b0; cpu_index_set = 1'b0; state = '0; ext_next_cpu_q = 1'b0;
        ext_vld = '0; ext_cpu_msg_in = '0; ext_cpu_index = '0;
    endtask

    // Load a value in a commit cycle, then spend one quiet evaluate cycle leaving SETTLE.
    task automatic load(input logic [31:0] v);
        idle_inputs();
        clk_oe = 1'b1; cpu_index_set = 1'b1; cpu_index_in = v;
        tick();
        check("load_settle", 32'(trk_state), 32'd2);
        idle_inputs();
        tick();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("rst_index", cpu_index_out, 32'h0);
        check("rst_state", 32'(trk_state), 32'd0);
        check("rst_err", 32'(idx_err), 32'd0);
        m_idx = '0; m_st = 0; m_err = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    function automatic logic [31:0] rand_sender(input logic [31:0] own);
        logic [31:0] v;
        case ($urandom_range(0, 3))
            0: v = own;
            1: v = {1'($urandom_range(0, 1)), 31'(own[30:0] + 31'($urandom_range(0, 4)) - 31'd2)};
            2: v = {1'($urandom_range(0, 1)), 31'($urandom_range(0, 3))};
            default: v = $urandom;
        endcase
        return v;
    endfunction

    initial begin
        idle_inputs();
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;

        // Commit with START_BEGIN activates an idle CPU.
        clk_oe = 1'b1; state = 2'(`START_BEGIN);
        tick();
        check("tp1_index", cpu_index_out, 32'h8000_0000);
        check("tp1_state", 32'(trk_state), 32'd1);

        // Active sender ending with a lower count decrements.
        load(32'h8000_0003);
        set_ch(0, 1'b1, 2'(`CPU_R_END), 32'h8000_0001);
        tick();
        check("tp2_index", cpu_index_out, 32'h8000_0002);

        // Increment and decrement in the same cycle cancel.
        idle_inputs();
        set_ch(0, 1'b1, 2'(`CPU_R_START), 32'h0000_0005);
        set_ch(1, 1'b1, 2'(`CPU_R_END), 32'h8000_0001);
        tick();
        check("tp3_index", cpu_index_out, 32'h8000_0002);

        // Inactive self: two inactive starters each decrement.
        load(32'h0000_0004);
        check("tp4_pre_state", 32'(trk_state), 32'd0);
        set_ch(0, 1'b1, 2'(`CPU_R_START), 32'h0000_0001);
        set_ch(1, 1'b1, 2'(`CPU_R_START), 32'h0000_0002);
        tick();
        check("tp4_index", cpu_index_out, 32'h0000_0002);

        // Messages arriving while settling are ignored.
        idle_inputs();
        clk_oe = 1'b1; cpu_index_set = 1'b1; cpu_index_in = 32'h8000_0007;
        tick();
        check("tp5_settle", 32'(trk_state), 32'd2);
        idle_inputs();
        set_ch(0, 1'b1, 2'(`CPU_R_END), 32'h8000_0001);
        tick();
        check("tp5_state", 32'(trk_state), 32'd1);
        check("tp5_index", cpu_index_out, 32'h8000_0007);

        // Underflow below zero: clamp or wrap.
        load(32'h0000_0000);
        set_ch(0, 1'b1, 2'(`CPU_R_START), 32'h0000_0003);
        tick();
`ifdef CPU_IDX_SAT_EN
        check("tp6_index", cpu_index_out, 32'h0000_0000);
        check("tp6_err", 32'(idx_err), 32'd1);
`else
        check("tp6_index", cpu_index_out, 32'h7FFF_FFFF);
        check("tp6_err", 32'(idx_err), 32'd0);
`endif

        // FINISH_END in commit returns to inactive zero.
        idle_inputs();
        clk_oe = 1'b1; state = 2'(`FINISH_END);
        tick();
        check("fin_index", cpu_index_out, 32'h0);
        check("fin_state", 32'(trk_state), 32'd0);

        // Own message at zero with START_BEGIN in evaluate activates.
        idle_inputs();
        state = 2'(`START_BEGIN);
        set_ch(2, 1'b1, 2'd0, 32'h0);
        tick();
        check("own_act_index", cpu_index_out, 32'h8000_0000);

        for (int i = 0; i < 3000; i++) begin
            if (i % 700 == 350) do_reset();
            clk_oe         = 1'($urandom_range(0, 1));
            cpu_index_set  = ($urandom_range(0, 15) == 0);
            cpu_index_in   = {1'($urandom_range(0, 1)),
                              ($urandom_range(0, 3) == 0) ? 31'h7FFF_FFFE + 31'($urandom_range(0, 1))
                                                          : 31'($urandom_range(0, 6))};
            state          = 2'($urandom_range(0, 3));
            ext_next_cpu_q = 1'($urandom_range(0, 1));
            for (int k = 0; k < NCH; k++)
                set_ch(k, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), rand_sender(m_idx));
            tick();
        end

        idle_inputs();
        tick();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
